quad_encoder_level: RTL and testbench

- Decodes a mechanical rotary quadrature encoder (raw A/B pins) into a WIDTH-bit brightness level.
- Drives the level input of one PWM channel of the RGB mixer; three instances in total, one per colour.
- Contains input synchronisers, per-channel debounce, a x4 quadrature decoder with detent accumulation, and a saturating/wrapping level register.

---
 rtl/rgb_mixer_pkg.sv | 26 ++
 rtl/debounce_sync.sv | 46 ++++
 rtl/quad_encoder_level.sv | 134 +++++++++++++
 tb/tb_quad_encoder_level.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_mixer_pkg.sv
// rtl/rgb_mixer_pkg.sv - shared constants and quadrature direction classifier
package rgb_mixer_pkg;

    localparam int LEVEL_WIDTH             = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_REV  = 2'd2,
        DIR_ERR  = 2'd3
    } quad_dir_e;

    // Forward order of {a,b} is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic quad_dir_e quad_classify(input logic [1:0] prev_ab,
                                                input logic [1:0] cur_ab);
        quad_dir_e dir;
        case ({prev_ab, cur_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dir = DIR_FWD;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dir = DIR_REV;
            default: dir = (prev_ab == cur_ab) ? DIR_NONE : DIR_ERR;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchroniser plus stable-count debounce for one bit
module debounce_sync
    import rgb_mixer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic debounced
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] stable_cnt;

    // Resynchronise the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a new value only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= '0;
            debounced  <= 1'b0;
        end else if (sync_2 == debounced) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            stable_cnt <= '0;
            debounced  <= sync_2;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_encoder_level.sv
// rtl/quad_encoder_level.sv - rotary quadrature encoder to saturating/wrapping brightness level
module quad_encoder_level
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH           = LEVEL_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int COUNTS_PER_STEP = 4,
    parameter int STEP            = 1,
    parameter bit SATURATE        = 1'b1,
    parameter int RESET_LEVEL     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] level,
    output logic             step_up,
    output logic             step_down,
    output logic             quad_err
);

    // Accumulator spans -4..+4 at most, so 4 signed bits are always enough.
    localparam int ACC_W = 4;
    localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_FULL  = ACC_W'(COUNTS_PER_STEP);
    localparam logic signed [ACC_W-1:0] ACC_EMPTY = -ACC_FULL;
    localparam logic [WIDTH:0]          STEP_W    = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0]        LEVEL_RST = WIDTH'(RESET_LEVEL);

    logic                    deb_a;
    logic                    deb_b;
    logic [1:0]              cur_ab;
    logic [1:0]              prev_ab;
    logic                    primed;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    quad_dir_e               dir;
    logic                    up_evt;
    logic                    dn_evt;
    logic                    err_evt;
    logic [WIDTH:0]          lvl_inc;
    logic [WIDTH:0]          lvl_dec;
    logic [WIDTH-1:0]        level_next;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk       (clk),
        .reset     (reset),
        .raw       (enc_a),
        .debounced (deb_a)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk       (clk),
        .reset     (reset),
        .raw       (enc_b),
        .debounced (deb_b)
    );

    assign cur_ab = {deb_a, deb_b};

    // Classify the debounced transition and advance the detent accumulator.
    always_comb begin
        dir      = primed ? quad_classify(prev_ab, cur_ab) : DIR_NONE;
        acc_next = acc;
        up_evt   = 1'b0;
        dn_evt   = 1'b0;
        err_evt  = 1'b0;
        case (dir)
            DIR_FWD: acc_next = acc + ACC_ONE;
            DIR_REV: acc_next = acc - ACC_ONE;
            DIR_ERR: begin
                err_evt  = 1'b1;
                acc_next = '0;
            end
            default: acc_next = acc;
        endcase
        if (acc_next == ACC_FULL) begin
            up_evt   = 1'b1;
            acc_next = '0;
        end else if (acc_next == ACC_EMPTY) begin
            dn_evt   = 1'b1;
            acc_next = '0;
        end
    end

    // Next level in WIDTH+1 bits so the carry/borrow shows whether to clamp.
    always_comb begin
        lvl_inc    = {1'b0, level} + STEP_W;
        lvl_dec    = {1'b0, level} - STEP_W;
        level_next = level;
        if (up_evt) begin
            if (SATURATE && lvl_inc[WIDTH]) begin
                level_next = '1;
            end else begin
                level_next = lvl_inc[WIDTH-1:0];
            end
        end else if (dn_evt) begin
            if (SATURATE && lvl_dec[WIDTH]) begin
                level_next = '0;
            end else begin
                level_next = lvl_dec[WIDTH-1:0];
            end
        end
    end

    // Decoder history: the first cycle out of reset only captures the resting position.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ab <= 2'b00;
            primed  <= 1'b0;
            acc     <= '0;
        end else begin
            prev_ab <= cur_ab;
            primed  <= 1'b1;
            acc     <= acc_next;
        end
    end

    // Registered level and event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= LEVEL_RST;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            quad_err  <= 1'b0;
        end else begin
            level     <= level_next;
            step_up   <= up_evt;
            step_down <= dn_evt;
            quad_err  <= err_evt;
        end
    end

endmodule

// File: tb/tb_quad_encoder_level.sv
// tb/tb_quad_encoder_level.sv - self-checking bench for quad_encoder_level
module tb_quad_encoder_level;

    localparam int D   = 4;
    localparam int CPS = 4;
    localparam int N   = 3;

    logic clk = 1'b0;
    logic reset;
    logic enc_a;
    logic enc_b;

    logic [7:0] lvl [N];
    logic       up  [N];
    logic       dn  [N];
    logic       err [N];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int cnt_up  [N] = '{0, 0, 0};
    int cnt_dn  [N] = '{0, 0, 0};
    int cnt_err [N] = '{0, 0, 0};

    always #5 clk = ~clk;

    quad_encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .COUNTS_PER_STEP(CPS), .STEP(1),
                         .SATURATE(1'b1), .RESET_LEVEL(0)) u_sat0 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .level(lvl[0]), .step_up(up[0]), .step_down(dn[0]), .quad_err(err[0]));

    quad_encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .COUNTS_PER_STEP(CPS), .STEP(1),
                         .SATURATE(1'b1), .RESET_LEVEL(254)) u_sat254 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .level(lvl[1]), .step_up(up[1]), .step_down(dn[1]), .quad_err(err[1]));

    quad_encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .COUNTS_PER_STEP(CPS), .STEP(1),
                         .SATURATE(1'b0), .RESET_LEVEL(255)) u_wrap255 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .level(lvl[2]), .step_up(up[2]), .step_down(dn[2]), .quad_err(err[2]));

    // ---------------- behavioural model ----------------
    int m_rl  [N] = '{0, 254, 255};
    bit m_sat [N] = '{1'b1, 1'b1, 1'b0};
    int m_lvl [N];
    bit m_up, m_dn, m_err;
    int m_s1a, m_s1b, m_s2a, m_s2b, m_da, m_db, m_pa, m_pb, m_acc;
    bit m_primed;
    int hist_a[$];
    int hist_b[$];

    // Position of {a,b} around the forward cycle 00,10,11,01.
    function automatic int ring_pos(input int a, input int b);
        if (a == 0 && b == 0) return 0;
        if (a == 1 && b == 0) return 1;
        if (a == 1 && b == 1) return 2;
        return 3;
    endfunction

    function automatic bit all_equal(input int q[$], input int v);
        if (q.size() < D) return 1'b0;
        foreach (q[k]) if (q[k] != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_s1a = 0; m_s1b = 0; m_s2a = 0; m_s2b = 0; m_da = 0; m_db = 0;
            m_pa = 0; m_pb = 0; m_acc = 0; m_primed = 1'b0;
            m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
            hist_a.delete(); hist_b.delete();
            for (int i = 0; i < N; i++) m_lvl[i] = m_rl[i];
        end else begin
            m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
            if (m_primed) begin
                int d;
                d = (ring_pos(m_da, m_db) - ring_pos(m_pa, m_pb) + 4) % 4;
                if (d == 2) begin
                    m_err = 1'b1;
                    m_acc = 0;
                end else if (d != 0) begin
                    m_acc = m_acc + ((d == 1) ? 1 : -1);
                    if (m_acc == CPS) begin m_up = 1'b1; m_acc = 0; end
                    else if (m_acc == -CPS) begin m_dn = 1'b1; m_acc = 0; end
                end
            end
            m_primed = 1'b1;
            m_pa = m_da; m_pb = m_db;
            for (int i = 0; i < N; i++) begin
                if (m_up)      m_lvl[i] = m_sat[i] ? ((m_lvl[i] == 255) ? 255 : m_lvl[i] + 1) : (m_lvl[i] + 1) % 256;
                else if (m_dn) m_lvl[i] = m_sat[i] ? ((m_lvl[i] == 0) ? 0 : m_lvl[i] - 1) : (m_lvl[i] + 255) % 256;
            end
            hist_a.push_back(m_s2a); if (hist_a.size() > D) void'(hist_a.pop_front());
            hist_b.push_back(m_s2b); if (hist_b.size() > D) void'(hist_b.pop_front());
            if (all_equal(hist_a, 1 - m_da)) m_da = 1 - m_da;
            if (all_equal(hist_b, 1 - m_db)) m_db = 1 - m_db;
            m_s2a = m_s1a; m_s2b = m_s1b;
            m_s1a = int'(enc_a); m_s1b = int'(enc_b);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model, plus pulse tallies.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("level[%0d]", i), int'(lvl[i]), m_lvl[i]);
                check($sformatf("step_up[%0d]", i), int'(up[i]), int'(m_up));
                check($sformatf("step_down[%0d]", i), int'(dn[i]), int'(m_dn));
                check($sformatf("quad_err[%0d]", i), int'(err[i]), int'(m_err));
                cnt_up[i]  += int'(up[i]);
                cnt_dn[i]  += int'(dn[i]);
                cnt_err[i] += int'(err[i]);
            end
        end
    end

    task automatic set_ab(input logic a, input logic b, input int n);
        enc_a = a;
        enc_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic fwd_detent();
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b0, 1'b0, 10);
    endtask

    task automatic rev_detent();
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b0, 1'b0, 10);
    endtask

    initial begin
        int up0, dn0, err0;
        reset = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_level0", int'(lvl[0]), 0);
        check("reset_level1", int'(lvl[1]), 254);
        check("reset_pulse", int'(up[0] | dn[0] | err[0]), 0);

        reset = 1'b0;
        set_ab(1'b0, 1'b0, 20);
        check("idle_level0", int'(lvl[0]), 0);
        check("idle_err", cnt_err[0], 0);

        fwd_detent();
        check("fwd1_level0", int'(lvl[0]), 1);
        check("fwd1_level1", int'(lvl[1]), 255);
        check("fwd1_level2", int'(lvl[2]), 0);
        check("fwd1_model0", m_lvl[0], 1);
        check("fwd1_ups", cnt_up[0], 1);

        repeat (3) fwd_detent();
        check("fwd4_level0", int'(lvl[0]), 4);
        check("fwd4_sat_level1", int'(lvl[1]), 255);
        check("fwd4_sat_ups1", cnt_up[1], 4);
        check("fwd4_level2", int'(lvl[2]), 3);

        repeat (6) rev_detent();
        check("rev6_clamp_level0", int'(lvl[0]), 0);
        check("rev6_downs0", cnt_dn[0], 6);
        check("rev6_level1", int'(lvl[1]), 249);
        check("rev6_wrap_level2", int'(lvl[2]), 253);
        check("rev6_model2", m_lvl[2], 253);

        up0 = cnt_up[0];
        dn0 = cnt_dn[0];
        set_ab(1'b1, 1'b0, 3);
        set_ab(1'b0, 1'b0, 6);
        set_ab(1'b1, 1'b0, 2);
        set_ab(1'b0, 1'b0, 1);
        set_ab(1'b1, 1'b0, 2);
        set_ab(1'b0, 1'b0, 1);
        set_ab(1'b1, 1'b0, 12);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b0, 1'b0, 10);
        check("bounce_ups", cnt_up[0] - up0, 0);
        check("bounce_downs", cnt_dn[0] - dn0, 0);
        check("bounce_level1", int'(lvl[1]), 249);

        err0 = cnt_err[0];
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b0, 10);
        check("err_pulses", cnt_err[0] - err0, 2);
        check("err_level1", int'(lvl[1]), 249);

        up0 = cnt_up[1];
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_level1", int'(lvl[1]), 254);
        check("midrst_level2", int'(lvl[2]), 255);
        reset = 1'b0;
        set_ab(1'b0, 1'b0, 5);
        set_ab(1'b1, 1'b0, 12);
        check("midrst_no_step", cnt_up[1] - up0, 0);
        check("midrst_hold1", int'(lvl[1]), 254);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
